// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-memory bridge.
package mem_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FB,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } state_t;

  // Address bit that separates SDRAM (clear) from config space (set)
  localparam int          CFG_SPACE_BIT = 15;
  localparam logic [15:0] FB_BASE_DFLT  = 16'hE000;
  localparam logic [15:0] FB_LAST_DFLT  = 16'hF2BF;
  // Read data returned when the SDRAM never answers
  localparam logic [15:0] TIMEOUT_DATA  = 16'hDEAD;

  function automatic logic in_window(input logic [15:0] a,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/mem_bridge_timeout.sv
// Watchdog counter for SDRAM transactions: cleared when a request is
// accepted, counts while enabled, flags expiry on its LIMIT-th cycle.
module mem_bridge_timeout #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  // Count enabled cycles; freeze at the expiry value until cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_expired = i_enable && (r_count == LAST);

endmodule

// File: rtl/mem_bridge.sv
// Bridge between the CPU memory request handshake and the SDRAM controller /
// VGA framebuffer port. One request in flight at a time.
// Optional build macro: MEM_BRIDGE_POSTED_WRITE_EN (SDRAM writes respond in
// the cycle after accept and finish in the background).
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter logic [15:0] FB_BASE   = FB_BASE_DFLT,
  parameter logic [15:0] FB_LAST   = FB_LAST_DFLT,
  parameter int          FB_ADDR_W = 13,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [15:0]          req_addr,
  input  logic [15:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [15:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [24:0]          sd_wr_addr,
  output logic [24:0]          sd_rd_addr,
  output logic [15:0]          sd_wr_data,
  output logic                 sd_wr_enable,
  output logic                 sd_rd_enable,
  input  logic [15:0]          sd_rd_data,
  input  logic                 sd_rd_ready,
  input  logic                 sd_busy,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [7:0]           fb_data,
  output logic                 fb_we
);

`ifdef MEM_BRIDGE_POSTED_WRITE_EN
  // Finished background writes go straight back to IDLE
  localparam state_t WR_DONE_ST = IDLE;
`else
  localparam state_t WR_DONE_ST = RESP;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_addr;
  logic [15:0]           r_wdata;
  logic [15:0]           r_rdata;
  logic                  r_write;
  logic                  r_err;
  logic                  r_busy_seen;
  logic                  r_rd_hit;
  logic                  w_accept;
  logic                  w_expired;
  logic                  w_tmo_en;
  logic                  w_tmo_hit;
  logic                  w_fb_hit;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_rsp;
  logic [FB_ADDR_W-1:0]  w_fb_off;

  assign w_accept = req_valid && req_ready;
  assign req_ready = (r_state == IDLE);
  assign w_tmo_en = (r_state == WR_ISSUE) || (r_state == WR_WAIT) ||
                    (r_state == RD_ISSUE) || (r_state == RD_WAIT);
  assign w_fb_hit = in_window(r_addr, FB_BASE, FB_LAST);
  assign w_fb_off = FB_ADDR_W'(r_addr - FB_BASE);

  mem_bridge_timeout #(
    .WIDTH (16),
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_accept),
    .i_enable  (w_tmo_en),
    .o_expired (w_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and SDRAM strobes; expiry beats issue, completion beats expiry
  always_comb begin
    w_next    = r_state;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    w_tmo_hit = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (req_addr[CFG_SPACE_BIT]) w_next = req_write ? FB : RESP;
          else                         w_next = req_write ? WR_ISSUE : RD_ISSUE;
        end
      end
      FB: w_next = RESP;
      WR_ISSUE: begin
        if (w_expired) begin
          w_tmo_hit = 1'b1;
          w_next    = WR_DONE_ST;
        end else if (!sd_busy) begin
          w_wr_en = 1'b1;
          w_next  = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (r_busy_seen && !sd_busy) begin
          w_next = WR_DONE_ST;
        end else if (w_expired) begin
          w_tmo_hit = 1'b1;
          w_next    = WR_DONE_ST;
        end
      end
      RD_ISSUE: begin
        if (w_expired) begin
          w_tmo_hit = 1'b1;
          w_next    = RESP;
        end else if (!sd_busy) begin
          w_rd_en = 1'b1;
          w_next  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (r_rd_hit || sd_rd_ready) begin
          w_next = RESP;
        end else if (w_expired) begin
          w_tmo_hit = 1'b1;
          w_next    = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latch, read-data capture, error and handshake-tracking flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_write     <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_busy_seen <= 1'b0;
      r_rd_hit    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_write <= req_write;
        r_rdata <= '0;
        r_err   <= 1'b0;
      end
      r_busy_seen <= w_accept ? 1'b0 : (r_busy_seen || ((r_state == WR_WAIT) && sd_busy));
      // A ready coinciding with the enable pulse is held until RD_WAIT sees it
      if (r_state == RD_WAIT)           r_rd_hit <= 1'b0;
      else if (w_rd_en && sd_rd_ready)  r_rd_hit <= 1'b1;
      if ((w_rd_en || ((r_state == RD_WAIT) && !r_rd_hit)) && sd_rd_ready)
        r_rdata <= sd_rd_data;
      if (w_tmo_hit) begin
        r_err   <= 1'b1;
        r_rdata <= TIMEOUT_DATA;
      end
    end
  end

`ifdef MEM_BRIDGE_POSTED_WRITE_EN
  logic r_posted_rsp;
  logic r_posted_err;

  // Early response for SDRAM writes and sticky background-timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_posted_rsp <= 1'b0;
      r_posted_err <= 1'b0;
    end else begin
      r_posted_rsp <= w_accept && req_write && !req_addr[CFG_SPACE_BIT];
      if (w_tmo_hit && r_write) r_posted_err <= 1'b1;
      else if (w_rsp)           r_posted_err <= 1'b0;
    end
  end

  assign w_rsp   = (r_state == RESP) || r_posted_rsp;
  assign rsp_err = w_rsp && (r_err || r_posted_err);
`else
  assign w_rsp   = (r_state == RESP);
  assign rsp_err = r_err;
`endif

  assign rsp_valid    = w_rsp;
  assign rsp_rdata    = r_rdata;
  assign sd_wr_addr   = {9'h0, r_addr};
  assign sd_rd_addr   = {9'h0, r_addr};
  assign sd_wr_data   = r_wdata;
  assign sd_wr_enable = w_wr_en;
  assign sd_rd_enable = w_rd_en;
  assign fb_we        = (r_state == FB) && r_write && w_fb_hit;
  assign fb_addr      = fb_we ? w_fb_off : '0;
  assign fb_data      = fb_we ? r_wdata[7:0] : '0;

endmodule

// File: tb/tb_mem_bridge.sv
// Randomized bench for mem_bridge with a transaction-level reference model
// and a small SDRAM controller model.
module tb_mem_bridge;
  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [24:0] sd_wr_addr;
  logic [24:0] sd_rd_addr;
  logic [15:0] sd_wr_data;
  logic        sd_wr_enable;
  logic        sd_rd_enable;
  logic [15:0] sd_rd_data;
  logic        sd_rd_ready;
  logic        sd_busy;
  logic [12:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_we;

  int n_checks = 0;
  int n_errors = 0;
  int req_id   = 0;
  int busy_rem = 0;
  int rd_rem   = -1;

  logic [15:0] ref_mem [0:32767];
  logic [15:0] ctl_mem [0:32767];

  mem_bridge #(
    .FB_BASE   (16'hE000),
    .FB_LAST   (16'hF2BF),
    .FB_ADDR_W (13),
    .TIMEOUT   (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .sd_wr_addr   (sd_wr_addr),
    .sd_rd_addr   (sd_rd_addr),
    .sd_wr_data   (sd_wr_data),
    .sd_wr_enable (sd_wr_enable),
    .sd_rd_enable (sd_rd_enable),
    .sd_rd_data   (sd_rd_data),
    .sd_rd_ready  (sd_rd_ready),
    .sd_busy      (sd_busy),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data),
    .fb_we        (fb_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s req%0d got 0x%0h expected 0x%0h", tag, req_id, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, req_ready, 1);
    check_val({tag, "_rsp_valid"}, rsp_valid, 0);
    check_val({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check_val({tag, "_rsp_err"},   rsp_err, 0);
    check_val({tag, "_wr_en"},     sd_wr_enable, 0);
    check_val({tag, "_rd_en"},     sd_rd_enable, 0);
    check_val({tag, "_wr_addr"},   sd_wr_addr, 0);
    check_val({tag, "_rd_addr"},   sd_rd_addr, 0);
    check_val({tag, "_wr_data"},   sd_wr_data, 0);
    check_val({tag, "_fb_we"},     fb_we, 0);
    check_val({tag, "_fb_addr"},   fb_addr, 0);
    check_val({tag, "_fb_data"},   fb_data, 0);
  endtask

  // Called at posedge+1. pre: busy cycles after accept; blen: busy cycles
  // after a write strobe; rlat: cycles from read strobe to ready.
  task automatic run_req(input bit w, input logic [15:0] a, input logic [15:0] d,
                         input int pre, input int blen, input int rlat, input bit rd_never);
    int cyc, acc_cyc, rsp_cyc, n_wr, n_rd, n_fb, exp_lat;
    bit accepted, done, both_on, cfg, in_win, exp_err;
    logic [24:0] wa, ra;
    logic [15:0] wd, got_rdata, exp_rdata;
    logic        got_err, got_ready;
    logic [12:0] fa;
    logic [7:0]  fd;
    req_id++;
    cfg    = a[15];
    in_win = (a >= 16'hE000) && (a <= 16'hF2BF);
    exp_err = !w && !cfg && rd_never;
    if (cfg)           exp_lat = w ? 2 : 1;
    else if (w)        exp_lat = 3 + pre + blen;
    else if (rd_never) exp_lat = TO + 1;
    else               exp_lat = (rlat == 0) ? 3 + pre : 2 + pre + rlat;
    if (w || cfg)      exp_rdata = 16'h0000;
    else if (rd_never) exp_rdata = 16'hDEAD;
    else               exp_rdata = ref_mem[a[14:0]];
    if (w && !cfg) ref_mem[a[14:0]] = d;

    cyc = 0; acc_cyc = 0; rsp_cyc = 0; n_wr = 0; n_rd = 0; n_fb = 0;
    accepted = 0; done = 0; both_on = 0;
    wa = '0; ra = '0; wd = '0; fa = '0; fd = '0;
    got_rdata = '0; got_err = 0; got_ready = 0;
    rd_rem = -1;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (sd_wr_enable && sd_rd_enable) both_on = 1;
      if (accepted && rsp_valid) begin
        done = 1; rsp_cyc = cyc;
        got_rdata = rsp_rdata; got_err = rsp_err; got_ready = req_ready;
      end
      if (sd_wr_enable) begin
        n_wr++; wa = sd_wr_addr; wd = sd_wr_data;
        ctl_mem[sd_wr_addr[14:0]] = sd_wr_data;
        busy_rem = blen;
      end
      if (sd_rd_enable) begin
        n_rd++; ra = sd_rd_addr;
        if (!rd_never) rd_rem = rlat;
      end
      if (fb_we) begin
        n_fb++; fa = fb_addr; fd = fb_data;
      end
      sd_rd_ready = 0;
      if (rd_rem == 0) begin
        sd_rd_ready = 1;
        sd_rd_data  = ctl_mem[ra[14:0]];
      end
      if (rd_rem >= 0) rd_rem--;
      if (!accepted && req_valid && req_ready) begin
        accepted = 1; acc_cyc = cyc; busy_rem = pre;
      end
      @(posedge clk); #1;
      if (accepted) req_valid = 0;
      sd_busy = (busy_rem > 0);
      if (busy_rem > 0) busy_rem--;
      cyc++;
    end
    req_valid = 0; sd_busy = 0; sd_rd_ready = 0;

    check_val("completed", done, 1);
    if (done) begin
      check_val("latency", rsp_cyc - acc_cyc, exp_lat);
      check_val("rsp_err", got_err, exp_err);
      if (!w) check_val("rsp_rdata", got_rdata, exp_rdata);
      check_val("ready_in_resp", got_ready, 0);
    end
    check_val("both_enables", both_on, 0);
    check_val("n_wr_pulses", n_wr, (w && !cfg) ? 1 : 0);
    check_val("n_rd_pulses", n_rd, (!w && !cfg) ? 1 : 0);
    check_val("n_fb_pulses", n_fb, (w && cfg && in_win) ? 1 : 0);
    if (w && !cfg) begin
      check_val("sd_wr_addr", wa, {9'h0, a});
      check_val("sd_wr_data", wd, d);
    end
    if (!w && !cfg) check_val("sd_rd_addr", ra, {9'h0, a});
    if (n_fb == 1) begin
      check_val("fb_addr", fa, 13'(a - 16'hE000));
      check_val("fb_data", fd, d[7:0]);
    end
    @(negedge clk);
    check_val("rsp_single_cycle", rsp_valid, 0);
    check_val("ready_after_resp", req_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int sel;
    logic [15:0] ra16, rd16;
    rst = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
    sd_rd_data = '0; sd_rd_ready = 0; sd_busy = 0;
    for (int i = 0; i < 32768; i++) begin
      ref_mem[i] = 16'(i) ^ 16'h5A5A;
      ctl_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 0;

    run_req(1, 16'h0123, 16'hBEEF, 0, 5, 0, 0);
    run_req(0, 16'h0123, 16'h0000, 0, 1, 3, 0);
    run_req(0, 16'h0123, 16'h0000, 0, 1, 0, 0);
    run_req(1, 16'hE005, 16'h12A7, 0, 1, 0, 0);
    run_req(1, 16'hF2C0, 16'h00FF, 0, 1, 0, 0);
    run_req(1, 16'hE000, 16'h0011, 0, 1, 0, 0);
    run_req(1, 16'hF2BF, 16'h0022, 0, 1, 0, 0);
    run_req(1, 16'hDFFF, 16'h0033, 0, 1, 0, 0);
    run_req(0, 16'h8000, 16'h0000, 0, 1, 0, 0);
    run_req(0, 16'h0042, 16'h0000, 0, 1, 0, 1);
    run_req(1, 16'h0010, 16'hA5A5, 3, 2, 0, 0);
    run_req(0, 16'h0010, 16'h0000, 2, 1, 1, 0);

    // Reset while waiting for the SDRAM write to finish
    req_id++;
    req_valid = 1; req_write = 1; req_addr = 16'h0200; req_wdata = 16'h5555;
    @(negedge clk);
    check_val("rst_accept_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
    @(negedge clk);
    check_val("rst_wr_strobe", sd_wr_enable, 1);
    @(posedge clk); #1;
    sd_busy = 1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 0; sd_busy = 0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check_val("rst_no_rsp", seen, 0);
    @(posedge clk); #1;
    run_req(1, 16'h0007, 16'h7777, 0, 3, 0, 0);
    run_req(0, 16'h0007, 16'h0000, 1, 1, 2, 0);

    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1:    ra16 = 16'($urandom_range(0, 31));
        2:       ra16 = 16'hE000 + 16'($urandom_range(0, 4800));
        default: ra16 = 16'h8000 | 16'($urandom_range(0, 32767));
      endcase
      rd16 = 16'($urandom);
      run_req(1'($urandom_range(0, 1)), ra16, rd16,
              $urandom_range(0, 3), $urandom_range(1, 8), $urandom_range(0, 8), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
